// File: rtl/decision_pkg.sv
// decision_pkg: definitions shared by the decision tree, its collector and benches.
//   CODE_Y1..CODE_Y4 : 8-bit class codes produced by the decision tree.
//   class_e          : 2-bit class encoding (Y1 = 0 .. Y4 = 3).
//   SEL_*            : statistics counter select values for cnt_sel_i.
package decision_pkg;

    localparam logic [7:0] CODE_Y1 = 8'h01;
    localparam logic [7:0] CODE_Y2 = 8'h02;
    localparam logic [7:0] CODE_Y3 = 8'h03;
    localparam logic [7:0] CODE_Y4 = 8'h04;

    typedef enum logic [1:0] {
        CLS_Y1 = 2'd0,
        CLS_Y2 = 2'd1,
        CLS_Y3 = 2'd2,
        CLS_Y4 = 2'd3
    } class_e;

    localparam logic [2:0] SEL_Y1   = 3'd0;
    localparam logic [2:0] SEL_Y2   = 3'd1;
    localparam logic [2:0] SEL_Y3   = 3'd2;
    localparam logic [2:0] SEL_Y4   = 3'd3;
    localparam logic [2:0] SEL_ERR  = 3'd4;
    localparam logic [2:0] SEL_DROP = 3'd5;

    localparam int NUM_CNT = 6;

    function automatic logic code_is_class(input logic [7:0] code);
        return (code >= CODE_Y1) && (code <= CODE_Y4);
    endfunction

    // Codes 1..4 map to 0..3; code 4 has low bits 00, so 00-1 wraps to 11.
    function automatic class_e code_to_class(input logic [7:0] code);
        return class_e'(code[1:0] - 2'd1);
    endfunction

endpackage

// File: rtl/decision_fifo.sv
// decision_fifo: synchronous FIFO with registered storage.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO).
//   push_i     : write data_i; ignored when full unless a pop fires in the same cycle.
//   pop_i      : remove head entry; ignored when empty.
//   data_i     : write data.
//   data_o     : head entry (combinational read of storage).
//   full_o     : DEPTH entries held.
//   empty_o    : no entries held.
module decision_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty once the write side has wrapped.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign push_ok = push_i && (!full_o || pop_ok);

    assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/decision_collector.sv
// decision_collector: captures each new decision from the decision tree, queues
// the class in a FIFO drained by valid/ready, and keeps saturating statistics.
//   clk, reset    : clock, synchronous active-high reset (clears everything).
//   y_i           : 8-bit class code from the tree.
//   y_valid_i     : level valid; a rising level is one decision.
//   clear_i       : zero all statistics counters (wins over increments).
//   class_o       : head-of-FIFO class (0 = Y1 .. 3 = Y4).
//   class_valid_o : FIFO non-empty.
//   class_ready_i : consumer takes class_o this cycle.
//   cnt_sel_i     : counter select (Y1..Y4, error, drop; 6-7 read 0).
//   cnt_o         : selected counter.
//   fifo_full_o   : FIFO holds DEPTH entries.
module decision_collector
    import decision_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       y_i,
    input  logic             y_valid_i,
    input  logic             clear_i,
    output logic [1:0]       class_o,
    output logic             class_valid_o,
    input  logic             class_ready_i,
    input  logic [2:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             fifo_full_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             prev_valid_q;
    logic             evt;
    logic             code_ok;
    class_e           cls;
    logic             push, pop, drop;
    logic             fifo_empty;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];

    // A held-high valid is a single decision; only the rising level counts.
    assign evt     = y_valid_i && !prev_valid_q;
    assign code_ok = code_is_class(y_i);
    assign cls     = code_to_class(y_i);

    assign push = evt && code_ok;
    assign pop  = class_valid_o && class_ready_i;
    assign drop = push && fifo_full_o && !pop;

    decision_fifo #(
        .DEPTH (DEPTH),
        .W     (2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (cls),
        .data_o  (class_o),
        .full_o  (fifo_full_o),
        .empty_o (fifo_empty)
    );

    assign class_valid_o = !fifo_empty;

    // Class counters advance even when the push is dropped for lack of space.
    always_comb begin
        inc      = '0;
        inc[3:0] = push ? (4'b0001 << cls) : 4'b0000;
        inc[SEL_ERR]  = evt && !code_ok;
        inc[SEL_DROP] = drop;
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_i)
                cnt_d[i] = '0;
            else if (inc[i] && (cnt_q[i] != CNT_MAX))
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else begin
            prev_valid_q <= y_valid_i;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        cnt_o = '0;
        case (cnt_sel_i)
            SEL_Y1:   cnt_o = cnt_q[0];
            SEL_Y2:   cnt_o = cnt_q[1];
            SEL_Y3:   cnt_o = cnt_q[2];
            SEL_Y4:   cnt_o = cnt_q[3];
            SEL_ERR:  cnt_o = cnt_q[4];
            SEL_DROP: cnt_o = cnt_q[5];
            default:  cnt_o = '0;
        endcase
    end

endmodule

// File: tb/tb_decision_collector.sv
// tb_decision_collector: directed bench for decision_collector. Main instance
// uses default parameters; a second instance with CNT_W=2 covers saturation.
module tb_decision_collector;
    import decision_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] y_i;
    logic       y_valid_i;
    logic       clear_i;
    logic [1:0] class_o;
    logic       class_valid_o;
    logic       class_ready_i;
    logic [2:0] cnt_sel_i;
    logic [7:0] cnt_o;
    logic       fifo_full_o;

    logic [7:0] y2;
    logic       v2, clr2;
    logic [2:0] sel2;
    logic [1:0] cls2;
    logic       cv2, full2;
    logic [1:0] cnt2;
    logic       rdy2 = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decision_collector #(.DEPTH(4), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .y_i           (y_i),
        .y_valid_i     (y_valid_i),
        .clear_i       (clear_i),
        .class_o       (class_o),
        .class_valid_o (class_valid_o),
        .class_ready_i (class_ready_i),
        .cnt_sel_i     (cnt_sel_i),
        .cnt_o         (cnt_o),
        .fifo_full_o   (fifo_full_o)
    );

    decision_collector #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .y_i           (y2),
        .y_valid_i     (v2),
        .clear_i       (clr2),
        .class_o       (cls2),
        .class_valid_o (cv2),
        .class_ready_i (rdy2),
        .cnt_sel_i     (sel2),
        .cnt_o         (cnt2),
        .fifo_full_o   (full2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        y_valid_i = 1'b0;
        v2        = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // One decision: valid high for one edge, then low for one edge.
    task automatic evt(input logic [7:0] code);
        y_i = code; y_valid_i = 1'b1;
        tick();
        y_valid_i = 1'b0;
        tick();
    endtask

    task automatic evt2(input logic [7:0] code);
        y2 = code; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        tick();
    endtask

    task automatic rd_cnt(input logic [2:0] sel, input logic [7:0] exp, input string tag);
        cnt_sel_i = sel;
        #1;
        chk(tag, cnt_o, exp);
    endtask

    initial begin
        int xfers;
        logic [1:0] exp_q [$];

        reset = 1'b1; y_i = '0; y_valid_i = 0; clear_i = 0; class_ready_i = 0;
        cnt_sel_i = '0; y2 = '0; v2 = 0; clr2 = 0; sel2 = '0;
        tick(); tick();
        chk("rst_valid", class_valid_o, 0);
        chk("rst_full",  fifo_full_o, 0);
        chk("rst_class", class_o, 0);
        for (int s = 0; s < 8; s++) rd_cnt(3'(s), 8'd0, "rst_cnt");
        reset = 1'b0;
        tick();

        // Held-high valid: one transfer only.
        y_i = CODE_Y3; y_valid_i = 1'b1; class_ready_i = 1'b1;
        xfers = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (class_valid_o) begin
                xfers++;
                chk("hold_class", class_o, 2);
            end
        end
        chk("hold_xfers", xfers, 1);
        rd_cnt(SEL_Y3, 8'd1, "hold_y3");
        y_valid_i = 1'b0;

        // Fill to full, fifth event dropped, then drain in order.
        do_reset();
        class_ready_i = 1'b0;
        evt(CODE_Y1); evt(CODE_Y2);
        chk("fill_notfull", fifo_full_o, 0);
        evt(CODE_Y4); evt(CODE_Y1);
        chk("fill_full", fifo_full_o, 1);
        evt(CODE_Y3);
        chk("drop_full", fifo_full_o, 1);
        rd_cnt(SEL_DROP, 8'd1, "drop_cnt");
        rd_cnt(SEL_Y3,   8'd1, "drop_y3");
        rd_cnt(SEL_Y1,   8'd2, "drop_y1");
        rd_cnt(SEL_Y4,   8'd1, "drop_y4");
        rd_cnt(SEL_ERR,  8'd0, "drop_err");
        exp_q = '{2'd0, 2'd1, 2'd3, 2'd0};
        class_ready_i = 1'b1;
        foreach (exp_q[i]) begin
            chk("drain_valid", class_valid_o, 1);
            chk("drain_class", class_o, exp_q[i]);
            tick();
        end
        chk("drain_empty", class_valid_o, 0);
        chk("drain_nfull", fifo_full_o, 0);

        // Bad code: error count only.
        do_reset();
        class_ready_i = 1'b0;
        evt(8'h07);
        chk("err_valid", class_valid_o, 0);
        rd_cnt(SEL_ERR, 8'd1, "err_cnt");
        for (int s = 0; s < 4; s++) rd_cnt(3'(s), 8'd0, "err_cls");
        rd_cnt(3'd7, 8'd0, "sel7");

        // Full FIFO with simultaneous push and pop.
        do_reset();
        class_ready_i = 1'b0;
        evt(CODE_Y1); evt(CODE_Y2); evt(CODE_Y3); evt(CODE_Y4);
        chk("pp_full0", fifo_full_o, 1);
        y_i = CODE_Y2; y_valid_i = 1'b1; class_ready_i = 1'b1;
        tick();
        y_valid_i = 1'b0; class_ready_i = 1'b0;
        chk("pp_full1", fifo_full_o, 1);
        chk("pp_head",  class_o, 1);
        rd_cnt(SEL_DROP, 8'd0, "pp_drop");
        rd_cnt(SEL_Y2,   8'd2, "pp_y2");
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd1};
        class_ready_i = 1'b1;
        foreach (exp_q[i]) begin
            chk("pp_valid", class_valid_o, 1);
            chk("pp_class", class_o, exp_q[i]);
            tick();
        end
        chk("pp_empty", class_valid_o, 0);

        // Throughput: back-to-back entries leave one per cycle.
        do_reset();
        class_ready_i = 1'b0;
        evt(CODE_Y4); evt(CODE_Y3);
        class_ready_i = 1'b1;
        chk("tp_c0", class_o, 3);
        tick();
        chk("tp_v1", class_valid_o, 1);
        chk("tp_c1", class_o, 2);
        tick();
        chk("tp_v2", class_valid_o, 0);

        // Saturation with CNT_W=2, then clear beats a coincident increment.
        sel2 = SEL_Y1;
        for (int i = 0; i < 5; i++) evt2(CODE_Y1);
        #1;
        chk("sat_y1", cnt2, 3);
        y2 = CODE_Y1; v2 = 1'b1; clr2 = 1'b1;
        tick();
        v2 = 1'b0; clr2 = 1'b0;
        #1;
        chk("clr_y1", cnt2, 0);
        // clear does not touch the FIFO: the coincident event still queued.
        chk("clr_fifo", cv2, 1);

        // Reset mid-operation with valid high.
        do_reset();
        class_ready_i = 1'b0;
        evt(CODE_Y1); evt(CODE_Y2); evt(CODE_Y3);
        chk("mid_valid0", class_valid_o, 1);
        y_i = CODE_Y4; y_valid_i = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid1", class_valid_o, 0);
        rd_cnt(SEL_Y1, 8'd0, "mid_y1");
        rd_cnt(SEL_Y3, 8'd0, "mid_y3");
        tick();
        chk("mid_valid2", class_valid_o, 1);
        chk("mid_class",  class_o, 3);
        rd_cnt(SEL_Y4, 8'd1, "mid_y4");
        y_valid_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
